// File: rtl/nibble_packer.sv
// Packs a stream of 4-bit nibbles into NIBBLES-wide words over valid/ready
// handshakes. A flush emits a partial word, zero-padded in its upper nibbles.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_data/valid/ready   nibble input handshake
//   flush                 request emission of a partially filled word
//   out_data/count/valid  packed word, held nibble count, valid
//   out_ready             consumer accepts the word
//   out_parity            ^out_data (only with NIBBLE_PACKER_PARITY_EN)
//
// Optional feature macro: NIBBLE_PACKER_PARITY_EN
module nibble_packer #(
  parameter int NIBBLES = 4,
  localparam int OUT_W = 4 * NIBBLES,
  localparam int CNT_W = $clog2(NIBBLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_valid,
`ifdef NIBBLE_PACKER_PARITY_EN
  output logic             out_parity,
`endif
  input  logic             out_ready
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  logic [OUT_W-1:0] asm_reg;
  logic [CNT_W-1:0] cnt;
  logic             flush_pend;

  logic             out_free;
  logic             in_xfer;
  logic             complete;
  logic             flush_eff;
  logic             emit;
  logic             pend_nxt;
  logic [OUT_W-1:0] merged;
  logic [CNT_W-1:0] fill;

  assign out_free = !out_valid | out_ready;
  // The last slot is only offered once the output register can take the word.
  assign in_ready = (cnt < LAST) | out_free;
  assign in_xfer  = in_valid & in_ready;
  assign complete = in_xfer & (cnt == LAST);
  assign flush_eff = flush_pend | flush;
  assign fill     = cnt + CNT_W'(in_xfer);

  // Current word including a nibble accepted this cycle.
  always_comb begin
    merged = asm_reg;
    for (int i = 0; i < NIBBLES; i++) begin
      if (in_xfer && cnt == CNT_W'(i)) begin
        merged[4*i +: 4] = in_data;
      end
    end
  end

  // complete implies out_free, via in_ready on the last slot.
  assign emit = complete |
                (flush_eff & out_free & ((cnt != '0) | in_xfer));

  always_comb begin
    pend_nxt = flush_eff;
    unique case (1'b1)
      emit:                       pend_nxt = 1'b0;
      (cnt == '0) && !in_xfer:    pend_nxt = 1'b0;
      default:                    pend_nxt = flush_eff;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_reg    <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
      out_data   <= '0;
      out_count  <= '0;
      out_valid  <= 1'b0;
    end else begin
      flush_pend <= pend_nxt;
      if (emit) begin
        asm_reg   <= '0;
        cnt       <= '0;
        out_data  <= merged;
        out_count <= fill;
        out_valid <= 1'b1;
      end else begin
        if (in_xfer) begin
          asm_reg <= merged;
          cnt     <= fill;
        end
        if (out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

`ifdef NIBBLE_PACKER_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_parity <= 1'b0;
    end else if (emit) begin
      out_parity <= ^merged;
    end
  end
`endif

endmodule

// File: tb/tb_nibble_packer.sv
// Testbench for nibble_packer: queue-based reference model checked every
// cycle, directed scenarios with literal word expectations, random traffic.
module tb_nibble_packer;

  localparam int N = 4;
  localparam int OUT_W = 4 * N;
  localparam int CNT_W = $clog2(N + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [OUT_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_valid;
  logic             out_ready;
`ifdef NIBBLE_PACKER_PARITY_EN
  logic             out_parity;
`endif

  nibble_packer #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_count (out_count),
    .out_valid (out_valid),
`ifdef NIBBLE_PACKER_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: nibbles held, pending flush, output register.
  logic [3:0]       mq[$];
  bit               m_pend = 0;
  bit               m_val = 0;
  logic [OUT_W-1:0] m_data = '0;
  int               m_cnt = 0;
  bit               m_par = 0;

  // Words the DUT actually handed over.
  logic [OUT_W-1:0] got_w[$];
  int               got_c[$];
  bit               got_p[$];

  function automatic bit m_in_ready();
    return (mq.size() < N - 1) || !m_val || out_ready;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_pend = 0;
      m_val = 0;
      m_data = '0;
      m_cnt = 0;
      m_par = 0;
    end else begin
      bit free, inx, eff;
      if (out_valid && out_ready) begin
        got_w.push_back(out_data);
        got_c.push_back(int'(out_count));
`ifdef NIBBLE_PACKER_PARITY_EN
        got_p.push_back(out_parity);
`else
        got_p.push_back(1'b0);
`endif
      end
      free = !m_val || out_ready;
      inx  = in_valid && m_in_ready();
      eff  = m_pend || flush;
      if (inx) mq.push_back(in_data);
      if (mq.size() == N || (eff && free && mq.size() > 0)) begin
        m_data = '0;
        foreach (mq[i]) m_data = m_data | (OUT_W'(mq[i]) << (4 * i));
        m_cnt = mq.size();
        m_par = ^m_data;
        m_val = 1;
        mq.delete();
        m_pend = 0;
      end else begin
        if (m_val && out_ready) m_val = 0;
        m_pend = (eff && mq.size() == 0) ? 1'b0 : eff;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_count", 32'(out_count), 32'd0);
`ifdef NIBBLE_PACKER_PARITY_EN
      chk("rst_out_parity", 32'(out_parity), 32'd0);
`endif
    end else begin
      chk("in_ready", 32'(in_ready), 32'(m_in_ready()));
      chk("out_valid", 32'(out_valid), 32'(m_val));
      if (m_val) begin
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_count", 32'(out_count), 32'(m_cnt));
`ifdef NIBBLE_PACKER_PARITY_EN
        chk("out_parity", 32'(out_parity), 32'(m_par));
`endif
      end
    end
  end

  // Offer one nibble until accepted; returns cycles spent.
  task automatic send(input logic [3:0] d, input bit fl, output int cyc);
    bit acc;
    in_valid = 1;
    in_data = d;
    flush = fl;
    cyc = 0;
    acc = 0;
    while (!acc && cyc < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 0;
    flush = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int c, tot, base;

  initial begin
    rst_n = 0;
    in_valid = 0;
    in_data = '0;
    flush = 0;
    out_ready = 1;
    idle(3);
    rst_n = 1;
    idle(1);

    // 1: single word
    base = got_w.size();
    for (int i = 1; i <= 4; i++) send(4'(i), 0, c);
    idle(2);
    chk("t1_nwords", 32'(got_w.size() - base), 32'd1);
    if (got_w.size() > base) begin
      chk("t1_word", 32'(got_w[base]), 32'h4321);
      chk("t1_count", 32'(got_c[base]), 32'd4);
    end

    // 2: continuous stream of 8 nibbles
    base = got_w.size();
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      send(4'(i), 0, c);
      tot += c;
    end
    idle(2);
    chk("t2_cycles", 32'(tot), 32'd8);
    chk("t2_nwords", 32'(got_w.size() - base), 32'd2);
    if (got_w.size() > base + 1) begin
      chk("t2_word0", 32'(got_w[base]), 32'h3210);
      chk("t2_word1", 32'(got_w[base + 1]), 32'h7654);
    end

    // 3: backpressure on a complete word
    base = got_w.size();
    out_ready = 0;
    for (int i = 5; i <= 8; i++) send(4'(i), 0, c);
    tot = 0;
    for (int i = 9; i <= 11; i++) begin
      send(4'(i), 0, c);
      tot += c;
    end
    chk("t3_three_free", 32'(tot), 32'd3);
    in_valid = 1;
    in_data = 4'hC;
    repeat (3) begin
      @(negedge clk);
      chk("t3_stall_ready", 32'(in_ready), 32'd0);
      chk("t3_stall_data", 32'(out_data), 32'h8765);
      @(posedge clk);
      #1;
    end
    out_ready = 1;
    @(negedge clk);
    chk("t3_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 0;
    idle(2);
    chk("t3_nwords", 32'(got_w.size() - base), 32'd2);
    if (got_w.size() > base + 1) begin
      chk("t3_wordA", 32'(got_w[base]), 32'h8765);
      chk("t3_wordB", 32'(got_w[base + 1]), 32'hCBA9);
    end

    // 4: flush of partial words
    base = got_w.size();
    send(4'hA, 0, c);
    send(4'hB, 0, c);
    flush = 1;
    idle(1);
    flush = 0;
    idle(2);
    send(4'hC, 1, c);
    idle(2);
    chk("t4_nwords", 32'(got_w.size() - base), 32'd2);
    if (got_w.size() > base + 1) begin
      chk("t4_word0", 32'(got_w[base]), 32'h00BA);
      chk("t4_count0", 32'(got_c[base]), 32'd2);
      chk("t4_word1", 32'(got_w[base + 1]), 32'h000C);
      chk("t4_count1", 32'(got_c[base + 1]), 32'd1);
    end

    // 5: empty flush, then reset mid-word
    base = got_w.size();
    flush = 1;
    idle(1);
    flush = 0;
    idle(3);
    chk("t5_empty_flush", 32'(got_w.size() - base), 32'd0);
    send(4'h7, 0, c);
    send(4'h6, 0, c);
    rst_n = 0;
    idle(2);
    rst_n = 1;
    idle(1);
    for (int i = 1; i <= 4; i++) send(4'(i), 0, c);
    idle(2);
    chk("t5_nwords", 32'(got_w.size() - base), 32'd1);
    if (got_w.size() > base) chk("t5_fresh", 32'(got_w[base]), 32'h4321);

`ifdef NIBBLE_PACKER_PARITY_EN
    // 6: parity of padded flush words
    base = got_w.size();
    send(4'h1, 1, c);
    idle(2);
    send(4'h3, 1, c);
    idle(2);
    chk("t6_nwords", 32'(got_w.size() - base), 32'd2);
    if (got_w.size() > base + 1) begin
      chk("t6_word0", 32'(got_w[base]), 32'h0001);
      chk("t6_par0", 32'(got_p[base]), 32'd1);
      chk("t6_word1", 32'(got_w[base + 1]), 32'h0003);
      chk("t6_par1", 32'(got_p[base + 1]), 32'd0);
    end
`endif

    // Random traffic, checked cycle by cycle against the model.
    for (int k = 0; k < 3000; k++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = 4'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 9) == 0);
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    flush = 0;
    out_ready = 1;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
